// File: rtl/multi_port_g_aetcam_array.sv
// Flip-flop ternary CAM with one write port and NUM_PORTS independent search ports.
// Each search port: match-vector register, then lowest-index priority encode register.
module multi_port_g_aetcam_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [DATA_WIDTH-1:0]           wr_mask,
  input  logic                            wr_valid,
  input  logic                            clear_all,
  input  logic [NUM_PORTS-1:0]            s_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_key,
  output logic [NUM_PORTS-1:0]            m_valid,
  output logic [NUM_PORTS-1:0]            m_hit,
  output logic [NUM_PORTS-1:0]            m_multi,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] m_addr,
  output logic [CNT_WIDTH-1:0]            num_valid
);

  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] mask_q [DEPTH];

  logic [DEPTH-1:0]     wr_sel_c;
  logic                 wr_hit_c;
  logic                 wr_old_valid_c;
  logic [CNT_WIDTH-1:0] num_valid_nxt_c;

  logic [NUM_PORTS-1:0][DEPTH-1:0] match_c;
  logic [NUM_PORTS-1:0]            s1_vld_q;
  logic [NUM_PORTS-1:0][DEPTH-1:0] s1_vec_q;

  logic [NUM_PORTS-1:0]                 enc_hit_c;
  logic [NUM_PORTS-1:0]                 enc_multi_c;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] enc_addr_c;

  // One-hot write decode; addresses at or above DEPTH select nothing.
  always_comb begin
    wr_sel_c = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      wr_sel_c[e] = wr_en && (wr_addr == ADDR_WIDTH'(e));
    end
  end

  assign wr_hit_c       = |wr_sel_c;
  assign wr_old_valid_c = |(valid_q & wr_sel_c);

  // Occupancy tracks valid-bit transitions; a clear collapses it to the written entry.
  always_comb begin
    num_valid_nxt_c = num_valid;
    if (clear_all) begin
      num_valid_nxt_c = (wr_hit_c && wr_valid) ? CNT_WIDTH'(1) : '0;
    end else if (wr_hit_c && wr_valid && !wr_old_valid_c) begin
      num_valid_nxt_c = num_valid + CNT_WIDTH'(1);
    end else if (wr_hit_c && !wr_valid && wr_old_valid_c) begin
      num_valid_nxt_c = num_valid - CNT_WIDTH'(1);
    end
  end

  // Entry storage: clear first, then the write to the selected entry overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      num_valid <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        data_q[e] <= '0;
        mask_q[e] <= '0;
      end
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (wr_sel_c[e]) begin
          valid_q[e] <= wr_valid;
          data_q[e]  <= wr_data;
          mask_q[e]  <= wr_mask;
        end else if (clear_all) begin
          valid_q[e] <= 1'b0;
        end
      end
      num_valid <= num_valid_nxt_c;
    end
  end

  // Ternary compare of every key against every entry (pre-write contents).
  always_comb begin
    match_c = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        match_c[p][e] = valid_q[e] &&
          (&((~(s_key[p*DATA_WIDTH +: DATA_WIDTH] ^ data_q[e])) | mask_q[e]));
      end
    end
  end

  // Stage 1: capture match vectors so later writes cannot disturb in-flight searches.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= '0;
      s1_vec_q <= '0;
    end else begin
      s1_vld_q <= s_valid;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        s1_vec_q[p] <= s_valid[p] ? match_c[p] : '0;
      end
    end
  end

  // Lowest-index priority encode; multi detects a second set bit.
  always_comb begin
    enc_hit_c   = '0;
    enc_multi_c = '0;
    enc_addr_c  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      enc_hit_c[p]   = |s1_vec_q[p];
      enc_multi_c[p] = |(s1_vec_q[p] & (s1_vec_q[p] - DEPTH'(1)));
      for (int e = int'(DEPTH) - 1; e >= 0; e--) begin
        if (s1_vec_q[p][e]) begin
          enc_addr_c[p] = ADDR_WIDTH'(e);
        end
      end
    end
  end

  // Stage 2: registered results, forced to zero when the port has no result.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= '0;
      m_hit   <= '0;
      m_multi <= '0;
      m_addr  <= '0;
    end else begin
      m_valid <= s1_vld_q;
      m_hit   <= s1_vld_q & enc_hit_c;
      m_multi <= s1_vld_q & enc_multi_c;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        m_addr[p*ADDR_WIDTH +: ADDR_WIDTH] <= s1_vld_q[p] ? enc_addr_c[p] : '0;
      end
    end
  end

endmodule

// File: tb/tb_multi_port_g_aetcam_array.sv
// Bench for multi_port_g_aetcam_array: result-level model with per-cycle compare,
// plus directed literal checks and a DEPTH=12 single-port instance for out-of-range writes.
module tb_multi_port_g_aetcam_array;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [31:0]  wr_mask;
  logic         wr_valid;
  logic         clear_all;
  logic [3:0]   s_valid;
  logic [127:0] s_key;
  logic [3:0]   m_valid;
  logic [3:0]   m_hit;
  logic [3:0]   m_multi;
  logic [15:0]  m_addr;
  logic [4:0]   num_valid;

  logic       b_wr_en;
  logic [3:0] b_wr_addr;
  logic [7:0] b_wr_data;
  logic [7:0] b_wr_mask;
  logic       b_wr_valid;
  logic       b_clear_all;
  logic [0:0] b_s_valid;
  logic [7:0] b_s_key;
  logic [0:0] b_m_valid;
  logic [0:0] b_m_hit;
  logic [0:0] b_m_multi;
  logic [3:0] b_m_addr;
  logic [3:0] b_num_valid;

  int checks = 0;
  int errors = 0;

  multi_port_g_aetcam_array dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_valid(wr_valid), .clear_all(clear_all),
    .s_valid(s_valid), .s_key(s_key), .m_valid(m_valid), .m_hit(m_hit),
    .m_multi(m_multi), .m_addr(m_addr), .num_valid(num_valid)
  );

  multi_port_g_aetcam_array #(.DATA_WIDTH(8), .DEPTH(12), .NUM_PORTS(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_mask(b_wr_mask), .wr_valid(b_wr_valid), .clear_all(b_clear_all),
    .s_valid(b_s_valid), .s_key(b_s_key), .m_valid(b_m_valid), .m_hit(b_m_hit),
    .m_multi(b_m_multi), .m_addr(b_m_addr), .num_valid(b_num_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mv;
  logic [31:0] md [16];
  logic [31:0] mm [16];
  logic [6:0]  e1_r [4];
  logic [6:0]  e2_r [4];
  logic        model_live = 1'b0;

  // {hit, multi, lowest matching index}: entry matches when unmasked bits agree.
  function automatic logic [5:0] model_search(input logic [31:0] key);
    int n = 0;
    logic [3:0] a = '0;
    for (int e = 15; e >= 0; e--) begin
      if (mv[e] && ((key & ~mm[e]) == (md[e] & ~mm[e]))) begin
        n++;
        a = 4'(e);
      end
    end
    return {n > 0, n > 1, a};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_live <= 1'b1;
      mv <= '0;
      for (int e = 0; e < 16; e++) begin
        md[e] <= '0;
        mm[e] <= '0;
      end
      for (int p = 0; p < 4; p++) begin
        e1_r[p] <= '0;
        e2_r[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        e2_r[p] <= e1_r[p];
        e1_r[p] <= s_valid[p] ? {1'b1, model_search(s_key[p*32 +: 32])} : 7'd0;
      end
      if (clear_all) mv <= '0;
      if (wr_en && int'(wr_addr) < 16) begin
        mv[wr_addr] <= wr_valid;
        md[wr_addr] <= wr_data;
        mm[wr_addr] <= wr_mask;
      end
    end
  end

  function automatic logic [6:0] dut_res(input int p);
    return {m_valid[p], m_hit[p], m_multi[p], m_addr[p*4 +: 4]};
  endfunction

  always @(negedge clk) begin
    if (model_live) begin
      for (int p = 0; p < 4; p++)
        chk($sformatf("model_port%0d", p), 64'(dut_res(p)), 64'(e2_r[p]));
      chk("model_num_valid", 64'(num_valid), 64'($countones(mv)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic write_entry(input logic [3:0] a, input logic [31:0] d,
                             input logic [31:0] m, input logic v);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m; wr_valid = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic b_write(input logic [3:0] a, input logic [7:0] d, input logic v);
    b_wr_en = 1'b1; b_wr_addr = a; b_wr_data = d; b_wr_mask = '0; b_wr_valid = v;
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  logic [31:0] keys [8];

  initial begin
    keys[0] = 32'h0000_FF12; keys[1] = 32'h0000_FF55; keys[2] = 32'h1234_BEEF;
    keys[3] = 32'h2000_0009; keys[4] = 32'h0000_0000; keys[5] = 32'hFFFF_FFFF;
    keys[6] = 32'h0000_BEEF; keys[7] = 32'h0000_FF00;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0; wr_valid = 1'b0;
    clear_all = 1'b0; s_valid = 4'hF; s_key = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_mask = '0; b_wr_valid = 1'b0;
    b_clear_all = 1'b0; b_s_valid = '0; b_s_key = '0;

    // Reset with searches requested
    repeat (2) @(negedge clk);
    chk("reset_m_valid", 64'(m_valid), 64'(0));
    chk("reset_num_valid", 64'(num_valid), 64'(0));

    rst = 1'b0; s_valid = 4'b0001; s_key = '0;
    @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    chk("post_reset_miss", 64'(dut_res(0)), 64'(7'b1_0_0_0000));

    // Exact and ternary hit
    write_entry(4'd3, 32'h0000_00A5, 32'h0, 1'b1);
    write_entry(4'd7, 32'h0000_00A0, 32'h0000_000F, 1'b1);
    s_valid = 4'b0011; s_key[31:0] = 32'h0000_00A5; s_key[63:32] = 32'h0000_00AC;
    @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    chk("exact_multi_p0", 64'(dut_res(0)), 64'(7'b1_1_1_0011));
    chk("ternary_p1", 64'(dut_res(1)), 64'(7'b1_1_0_0111));

    // Write/search collision
    s_valid = 4'b0100; s_key[95:64] = 32'h0000_1234;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h0000_1234; wr_mask = '0; wr_valid = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    s_valid = '0;
    chk("collision_miss", 64'(dut_res(2)), 64'(7'b1_0_0_0000));
    @(negedge clk);
    chk("after_write_hit", 64'(dut_res(2)), 64'(7'b1_1_0_0101));

    // Fill, invalidate, rewrite
    for (int e = 0; e < 16; e++) write_entry(4'(e), 32'h1000_0000 + e, 32'h0, 1'b1);
    chk("full_count", 64'(num_valid), 64'(16));
    write_entry(4'd0, 32'h0, 32'h0, 1'b0);
    chk("invalidate_count", 64'(num_valid), 64'(15));
    write_entry(4'd1, 32'h1000_0001, 32'h0, 1'b1);
    chk("rewrite_count", 64'(num_valid), 64'(15));

    // Out-of-range write on the DEPTH=12 instance
    b_write(4'd11, 8'h5A, 1'b1);
    chk("b_count_1", 64'(b_num_valid), 64'(1));
    b_write(4'd13, 8'h5A, 1'b1);
    chk("b_oor13_count", 64'(b_num_valid), 64'(1));
    b_write(4'd12, 8'h5A, 1'b1);
    chk("b_oor12_count", 64'(b_num_valid), 64'(1));
    b_s_valid = 1'b1; b_s_key = 8'h5A;
    @(negedge clk);
    b_s_valid = 1'b0;
    @(negedge clk);
    chk("b_search", 64'({b_m_valid, b_m_hit, b_m_multi, b_m_addr}), 64'(7'b1_1_0_1011));

    // Down to 10 valid, then clear_all with a simultaneous write
    for (int e = 11; e < 16; e++) write_entry(4'(e), 32'h0, 32'h0, 1'b0);
    chk("ten_valid", 64'(num_valid), 64'(10));
    clear_all = 1'b1;
    write_entry(4'd9, 32'h2000_0009, 32'h0, 1'b1);
    clear_all = 1'b0;
    chk("clear_write_count", 64'(num_valid), 64'(1));
    s_valid = 4'b0011; s_key[31:0] = 32'h2000_0009; s_key[63:32] = 32'h1000_0001;
    @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    chk("clear_only9_hit", 64'(dut_res(0)), 64'(7'b1_1_0_1001));
    chk("clear_old_miss", 64'(dut_res(1)), 64'(7'b1_0_0_0000));

    // Parallel ports every cycle, with a write mid-stream
    write_entry(4'd2, 32'h0000_FF00, 32'h0000_00FF, 1'b1);
    write_entry(4'd4, 32'h0000_FF12, 32'h0, 1'b1);
    write_entry(4'd6, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b1);
    for (int c = 0; c < 8; c++) begin
      s_valid = 4'hF;
      for (int p = 0; p < 4; p++) s_key[p*32 +: 32] = keys[(c + p) % 8];
      if (c == 3) begin
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h0; wr_mask = 32'h0; wr_valid = 1'b0;
      end
      @(negedge clk);
      wr_en = 1'b0;
    end
    chk("par_last_p0", 64'(dut_res(0)), 64'(7'b1_1_0_0110));

    // Reset with searches in flight
    rst = 1'b1; s_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_quiet%0d", i), 64'(m_valid), 64'(0));
      @(negedge clk);
    end
    s_valid = 4'b1000; s_key[127:96] = 32'h0000_FF55;
    @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    chk("post_midrst", 64'({m_valid, dut_res(3)}), 64'({4'b1000, 7'b1_0_0_0000}));
    chk("post_midrst_count", 64'(num_valid), 64'(0));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
